// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one of two requesters the single-port memory and sequences WAIT_CYC access cycles.
// Define ARB_ROUND_ROBIN_EN to alternate on ties; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state, state_nx;
    logic       owner;
    logic       sel;
    logic       last;
    logic       we_q;
    logic [3:0] cnt;

    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYC must be in 1..15");
    end

    assign last = cnt == 4'(WAIT_CYC - 1);

    // owner doubles as the last-owner pointer: it only changes on a grant
`ifdef ARB_ROUND_ROBIN_EN
    assign sel = (m0_req && m1_req) ? ~owner : m1_req;
`else
    assign sel = ~m0_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE)   ? ((m0_req || m1_req) ? ACCESS : IDLE) :
                   (state == ACCESS) ? (last ? DONE : ACCESS) : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= 1'b1;
            we_q      <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else if (state == IDLE) begin
            if (m0_req || m1_req) begin
                owner     <= sel;
                we_q      <= sel ? m1_we : m0_we;
                mem_addr  <= sel ? m1_addr : m0_addr;
                mem_wdata <= sel ? m1_wdata : m0_wdata;
                cnt       <= '0;
            end
        end else if (state == ACCESS) begin
            cnt <= cnt + 4'd1;
            if (last && !we_q) begin
                if (owner) m1_rdata <= mem_rdata;
                else       m0_rdata <= mem_rdata;
            end
        end
    end

    assign m0_gnt  = (state != IDLE) && !owner;
    assign m1_gnt  = (state != IDLE) && owner;
    assign m0_done = (state == DONE) && !owner;
    assign m1_done = (state == DONE) && owner;
    assign mem_en  = state == ACCESS;
    assign mem_we  = mem_en && we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (WAIT_CYC=1 and 3) against a transaction-level model of memory contents,
// per-port read data and the last-owner arbitration rule.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b1;
    logic [1:0]    m0_req, m1_req, m0_we, m1_we, m0_gnt, m1_gnt, m0_done, m1_done, mem_en, mem_we;
    logic [AW-1:0] m0_addr[2], m1_addr[2], mem_addr[2];
    logic [DW-1:0] m0_wdata[2], m1_wdata[2], m0_rdata[2], m1_rdata[2], mem_wdata[2], mem_rdata[2];
    logic [DW-1:0] dev_mem[2][256];

    logic [DW-1:0] ref_mem[2][256];
    logic [DW-1:0] ref_rd[2][2];
    logic          ref_ptr[2];
    logic          mw[2];
    logic [AW-1:0] ma[2];
    logic [DW-1:0] md[2];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
            .m0_gnt(m0_gnt[g]), .m0_done(m0_done[g]), .m0_rdata(m0_rdata[g]),
            .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
            .m1_gnt(m1_gnt[g]), .m1_done(m1_done[g]), .m1_rdata(m1_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );
        assign mem_rdata[g] = dev_mem[g][mem_addr[g][7:0]];
    end

    function automatic logic [31:0] pat(int i);
        return (i == 'h40) ? 32'h12345678 : (32'hA5A50000 ^ (32'(i) * 32'h00010203));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                for (int i = 0; i < 256; i++) dev_mem[k][i] <= pat(i);
            end else if (mem_en[k] && mem_we[k]) begin
                dev_mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int k, int p, logic r);
        if (p == 0) begin
            m0_req[k] = r; m0_we[k] = mw[0]; m0_addr[k] = ma[0]; m0_wdata[k] = md[0];
        end else begin
            m1_req[k] = r; m1_we[k] = mw[1]; m1_addr[k] = ma[1]; m1_wdata[k] = md[1];
        end
    endtask

    task automatic newfields(int p);
        mw[p] = 1'($urandom_range(0, 1));
        ma[p] = 32'($urandom_range(0, 127));
        md[p] = $urandom;
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            ref_ptr[k] = 1'b1;
            ref_rd[k][0] = '0;
            ref_rd[k][1] = '0;
        end
    endtask

    task automatic chk_reset(int k, string tag);
        chk({tag, "_gnt"}, 32'({m1_gnt[k], m0_gnt[k]}), 0);
        chk({tag, "_done"}, 32'({m1_done[k], m0_done[k]}), 0);
        chk({tag, "_en_we"}, 32'({mem_en[k], mem_we[k]}), 0);
        chk({tag, "_addr"}, mem_addr[k], 0);
        chk({tag, "_wdata"}, mem_wdata[k], 0);
        chk({tag, "_m0_rdata"}, m0_rdata[k], 0);
        chk({tag, "_m1_rdata"}, m1_rdata[k], 0);
    endtask

    // Observes instance k each cycle until a done pulse; returns the finishing port and cycles waited.
    task automatic wait_done(int k, output int p, output int n);
        logic [1:0] g, d;
        p = -1;
        n = 0;
        while (p < 0 && n < 40) begin
            @(negedge clk);
            n++;
            g = {m1_gnt[k], m0_gnt[k]};
            d = {m1_done[k], m0_done[k]};
            chk("gnt_excl", 32'(g[0] & g[1]), 0);
            for (int q = 0; q < 2; q++) begin
                if (g[q] && !d[q]) begin
                    chk("acc_en", 32'(mem_en[k]), 1);
                    chk("acc_we", 32'(mem_we[k]), 32'(mw[q]));
                    chk("acc_addr", mem_addr[k], ma[q]);
                    if (mw[q]) chk("acc_wdata", mem_wdata[k], md[q]);
                end
            end
            if (g == 2'b00) chk("idle_en", 32'({mem_en[k], d}), 0);
            if (d != 2'b00) begin
                p = d[1] ? 1 : 0;
                chk("done_excl", 32'(d), p ? 2 : 1);
                chk("done_gnt", 32'(g[p]), 1);
                chk("done_en_we", 32'({mem_en[k], mem_we[k]}), 0);
                if (mw[p]) ref_mem[k][ma[p][7:0]] = md[p];
                else       ref_rd[k][p] = ref_mem[k][ma[p][7:0]];
                ref_ptr[k] = p[0];
                chk("m0_rdata", m0_rdata[k], ref_rd[k][0]);
                chk("m1_rdata", m1_rdata[k], ref_rd[k][1]);
            end
        end
        if (p < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic single(int k, int p, logic we, logic [31:0] a, logic [31:0] d, logic wig);
        int q, n;
        @(negedge clk);
        mw[p] = we; ma[p] = a; md[p] = d;
        drive(k, p, 1'b1);
        chk("pre_gnt", 32'({m1_gnt[k], m0_gnt[k], mem_en[k]}), 0);
        if (wig) begin
            @(posedge clk);
            #1;
            if (p == 0) m0_addr[k] = a ^ 32'h4;
            else        m1_addr[k] = a ^ 32'h4;
        end
        wait_done(k, q, n);
        chk("single_port", q, p);
        chk("single_latency", n, k ? 4 : 2);
        @(posedge clk);
        #1 drive(k, p, 1'b0);
    endtask

    task automatic tie(int k, int cnt, logic rnd);
        int q, n, ex;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (rnd) newfields(p);
            drive(k, p, 1'b1);
        end
        for (int i = 0; i < cnt; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            ex = ref_ptr[k] ? 0 : 1;
`else
            ex = 0;
`endif
            wait_done(k, q, n);
            chk("tie_winner", q, ex);
            chk("tie_latency", n, (k ? 4 : 2) + (i > 0 ? 1 : 0));
            @(posedge clk);
            #1;
            if (rnd && q >= 0) begin
                newfields(q);
                drive(k, q, 1'b1);
            end
        end
        drive(k, 0, 1'b0);
        drive(k, 1, 1'b0);
    endtask

    initial begin
        int q, n;
        m0_req = '0; m1_req = '0; m0_we = '0; m1_we = '0;
        for (int k = 0; k < 2; k++) begin
            m0_addr[k] = '0; m1_addr[k] = '0; m0_wdata[k] = '0; m1_wdata[k] = '0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = pat(i);
        end
        for (int p = 0; p < 2; p++) begin
            mw[p] = 1'b0; ma[p] = '0; md[p] = '0;
        end
        reset_model();
        repeat (3) @(negedge clk);
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");
        load = 1'b0;
        rst = 1'b1;

        single(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        single(0, 0, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("w1_readback", m0_rdata[0], 32'hDEADBEEF);

        single(1, 1, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("w3_preload", m1_rdata[1], 32'h12345678);
        chk("w3_m0_untouched", m0_rdata[1], 32'h0);

        mw[0] = 1'b0; ma[0] = 32'h10; md[0] = '0;
        mw[1] = 1'b0; ma[1] = 32'h40; md[1] = '0;
        tie(0, 4, 1'b0);
        tie(1, 4, 1'b0);

        @(negedge clk);
        mw[0] = 1'b1; ma[0] = 32'h30; md[0] = 32'hCAFEF00D;
        drive(1, 0, 1'b1);
        @(negedge clk);
        chk("ovl_m0_gnt", 32'({m1_gnt[1], m0_gnt[1]}), 1);
        mw[1] = 1'b0; ma[1] = 32'h30; md[1] = '0;
        drive(1, 1, 1'b1);
        wait_done(1, q, n);
        chk("ovl_first", q, 0);
        chk("ovl_first_lat", n, 3);
        @(posedge clk);
        #1 drive(1, 0, 1'b0);
        wait_done(1, q, n);
        chk("ovl_second", q, 1);
        chk("ovl_second_lat", n, 5);
        chk("ovl_m1_rdata", m1_rdata[1], 32'hCAFEF00D);
        @(posedge clk);
        #1 drive(1, 1, 1'b0);

        single(1, 0, 1'b0, 32'h20, 32'h0, 1'b1);

        repeat (30) begin
            newfields(0);
            single(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), mw[0], ma[0], md[0], 1'b0);
        end
        repeat (6) tie(int'($urandom_range(0, 1)), int'($urandom_range(2, 5)), 1'b1);

        @(negedge clk);
        mw[0] = 1'b1; ma[0] = 32'hF0; md[0] = $urandom;
        drive(1, 0, 1'b1);
        repeat (2) @(negedge clk);
        chk("pre_rst_en", 32'({m0_gnt[1], mem_en[1]}), 3);
        rst = 1'b0;
        #1;
        chk_reset(1, "mid_rst");
        drive(1, 0, 1'b0);
        reset_model();
        @(posedge clk);
        @(negedge clk);
        chk_reset(1, "held_rst");
        rst = 1'b1;
        mw[0] = 1'b0; ma[0] = 32'h10; md[0] = '0;
        mw[1] = 1'b0; ma[1] = 32'h40; md[1] = '0;
        tie(1, 1, 1'b0);
        single(1, 1, 1'b0, 32'h41, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
